// File: rtl/e1_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e1_ddr_pkg
// Description : Shared types and constants for the E1 DDR write path.
// Revision    : 1.0 - initial release
// ============================================================================
package e1_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Must track the p2s stage's beat count and the MIG address width.
    localparam int E1_SEQ_CNT    = 5;
    localparam int E1_ADDR_WIDTH = 28;

endpackage
`default_nettype wire

// File: rtl/e1_wr_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : e1_wr_cmd_seq_if
// Description : Request, MIG command and p2s beat signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface e1_wr_cmd_seq_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int CMD_WIDTH  = 3
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_ready;
    logic                  par_en;
    logic                  app_rdy;
    logic                  app_en;
    logic [CMD_WIDTH-1:0]  app_cmd;
    logic [ADDR_WIDTH-1:0] app_addr;
    logic                  wdf_beat;
    logic                  wdf_last;
    logic                  wr_done;
    logic                  proto_err;

    modport slave (
        input  wr_req, wr_addr, app_rdy, wdf_beat, wdf_last,
        output wr_ready, par_en, app_en, app_cmd, app_addr, wr_done, proto_err
    );

    modport master (
        output wr_req, wr_addr, app_rdy, wdf_beat, wdf_last,
        input  wr_ready, par_en, app_en, app_cmd, app_addr, wr_done, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/e1_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : e1_beat_cnt
// Description : Up-counter to MAX with clear, terminal (MAX-1) and full flags.
// Revision    : 1.0 - initial release
// ============================================================================
module e1_beat_cnt #(
    parameter int MAX = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_tc,
    output logic      o_full
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc   = (r_cnt == W'(MAX - 1));
    assign o_full = (r_cnt == W'(MAX));
endmodule
`default_nettype wire

// File: rtl/e1_wr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : e1_wr_cmd_seq
// Description : Issues SEQ_CNT MIG WRITE commands per request, tracks p2s beats.
//               Optional stall counter output: define E1_WR_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module e1_wr_cmd_seq
    import e1_ddr_pkg::*;
#(
    parameter int SEQ_CNT     = E1_SEQ_CNT,
    parameter int ADDR_WIDTH  = E1_ADDR_WIDTH,
    parameter int ADDR_STRIDE = 8,
    parameter int CMD_WIDTH   = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    e1_wr_cmd_seq_if.slave     bus
`ifdef E1_WR_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);
    state_t                r_state;
    logic                  r_wr_ready;
    logic                  r_app_en;
    logic [ADDR_WIDTH-1:0] r_app_addr;
    logic                  r_wr_done;
    logic                  r_proto_err;

    logic w_accept;
    logic w_active;
    logic w_cmd_inc;
    logic w_cmd_tc;
    logic w_cmd_full;
    logic w_dat_inc;
    logic w_dat_tc;
    logic w_dat_full;
    logic w_dat_end;
    logic w_err;

    assign w_accept  = bus.wr_req & r_wr_ready;
    assign w_active  = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_cmd_inc = r_app_en & bus.app_rdy & ~w_cmd_full;
    assign w_dat_inc = bus.wdf_beat & w_active;
    // Data is complete if already counted or the final beat lands this cycle.
    assign w_dat_end = w_dat_full | (w_dat_tc & bus.wdf_beat);
    assign w_err     = bus.wdf_beat & (~w_active
                                       | (bus.wdf_last & ~w_dat_tc)
                                       | (w_dat_tc & ~bus.wdf_last));

    e1_beat_cnt #(.MAX(SEQ_CNT)) u_cmd_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_cmd_inc),
        .o_tc   (w_cmd_tc),
        .o_full (w_cmd_full)
    );

    e1_beat_cnt #(.MAX(SEQ_CNT)) u_dat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_dat_inc),
        .o_tc   (w_dat_tc),
        .o_full (w_dat_full)
    );

    // app_addr is kept as a running register: base, then +ADDR_STRIDE per
    // accepted command, which equals base + cmd_cnt*ADDR_STRIDE mod 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_ready  <= 1'b1;
            r_app_en    <= 1'b0;
            r_app_addr  <= '0;
            r_wr_done   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_app_addr <= bus.wr_addr;
                        r_wr_ready <= 1'b0;
                        r_app_en   <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.app_rdy) begin
                        r_app_addr <= r_app_addr + ADDR_WIDTH'(ADDR_STRIDE);
                        if (w_cmd_tc) begin
                            r_app_en <= 1'b0;
                            if (w_dat_end) begin
                                r_wr_done <= 1'b1;
                                r_state   <= DONE;
                            end else begin
                                r_state   <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_dat_end) begin
                        r_wr_done <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_wr_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready  = r_wr_ready;
    assign bus.par_en    = w_accept;
    assign bus.app_en    = r_app_en;
    assign bus.app_cmd   = CMD_WIDTH'(CMD_WRITE);
    assign bus.app_addr  = r_app_addr;
    assign bus.wr_done   = r_wr_done;
    assign bus.proto_err = r_proto_err;

`ifdef E1_WR_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_app_en && !bus.app_rdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_e1_wr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_e1_wr_cmd_seq
// Description : Scoreboard bench for e1_wr_cmd_seq (addresses, completion, errors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e1_wr_cmd_seq;
    localparam int SEQ    = 5;
    localparam int AW     = 28;
    localparam int STRIDE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    e1_wr_cmd_seq_if #(.ADDR_WIDTH(AW), .CMD_WIDTH(3)) bus ();

`ifdef E1_WR_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] sc0;
`endif

    e1_wr_cmd_seq #(
        .SEQ_CNT     (SEQ),
        .ADDR_WIDTH  (AW),
        .ADDR_STRIDE (STRIDE),
        .CMD_WIDTH   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef E1_WR_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          par_cnt = 0;
    logic [AW-1:0] addr_q[$];
    int          done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: commands and completions as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.par_en) par_cnt++;
            if (bus.app_en && bus.app_rdy) begin
                chk("app_cmd", 32'(bus.app_cmd), 32'h0);
                if (addr_q.size() == 0) chk("cmd_unexpected", 1, 0);
                else chk("cmd_addr", 32'(bus.app_addr), 32'(addr_q.pop_front()));
            end
            if (bus.wr_done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // One request; j counts cycles from the first ISSUE cycle. Completion is
    // expected in the cycle after the later of the last command and last beat.
    task automatic do_req(input logic [AW-1:0] base, input int stall_cmd, input int stall_len,
                          input int lag, input bit busy, input bit err, input bit exp_err);
        int k, b, s, j, n, pc0, last_cmd_j, last_beat_j;
        logic [AW-1:0] a;
        bit prev_rdy;
        k = 0; b = 0; s = 0; j = 0; pc0 = par_cnt;
        for (int i = 0; i < SEQ; i++) begin
            a = base + AW'(i * STRIDE);
            addr_q.push_back(a);
        end
        last_cmd_j  = (stall_cmd < SEQ) ? (SEQ - 1 + stall_len) : (SEQ - 1);
        last_beat_j = lag + SEQ - 1;
        done_q.push_back(cyc + 2 + ((last_cmd_j > last_beat_j) ? last_cmd_j : last_beat_j));
        bus.wr_req  = 1'b1;
        bus.wr_addr = base;
        tick();
        bus.wr_req  = 1'b0;
        while ((k < SEQ || b < SEQ) && j < 60) begin
            bus.app_rdy  = !(k == stall_cmd && s < stall_len);
            if (!bus.app_rdy) s++;
            bus.wdf_beat = (j >= lag) && (b < SEQ);
            bus.wdf_last = bus.wdf_beat && (b == (err ? 2 : SEQ - 1));
            bus.wr_req   = busy && (j == 2);
            if (busy && j == 2) bus.wr_addr = 28'h5A5A000;
            prev_rdy = bus.app_rdy;
            tick();
            if (prev_rdy && k < SEQ) k++;
            if (bus.wdf_beat) b++;
            j++;
            if (!prev_rdy && k < SEQ) begin
                a = base + AW'(k * STRIDE);
                chk("stall_app_en", 32'(bus.app_en), 1);
                chk("stall_addr", 32'(bus.app_addr), 32'(a));
            end
            if (k == SEQ && b < SEQ) begin
                chk("drain_app_en", 32'(bus.app_en), 0);
                chk("drain_wr_ready", 32'(bus.wr_ready), 0);
            end
        end
        if (j >= 60) chk("req_timeout", 0, 1);
        bus.wdf_beat = 1'b0;
        bus.wdf_last = 1'b0;
        bus.app_rdy  = 1'b1;
        bus.wr_req   = 1'b0;
        n = 0;
        while (done_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (done_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            done_q.delete();
        end
        chk("ready_after_done", 32'(bus.wr_ready), 1);
        chk("done_pulse_width", 32'(bus.wr_done), 0);
        chk("par_en_count", par_cnt - pc0, 1);
        chk("proto_err", 32'(bus.proto_err), 32'(exp_err));
        chk("cmds_left", addr_q.size(), 0);
        addr_q.delete();
    endtask

    initial begin
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.app_rdy  = 1'b1;
        bus.wdf_beat = 1'b0;
        bus.wdf_last = 1'b0;
        repeat (3) tick();
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_app_en", 32'(bus.app_en), 0);
        chk("rst_app_addr", 32'(bus.app_addr), 0);
        chk("rst_wr_done", 32'(bus.wr_done), 0);
        chk("rst_proto_err", 32'(bus.proto_err), 0);
        chk("rst_app_cmd", 32'(bus.app_cmd), 0);
        rst = 1'b0;
        tick();

        do_req(28'h100, 99, 0, 0, 1'b0, 1'b0, 1'b0);       // nominal
`ifdef E1_WR_STALL_CNT_EN
        sc0 = stall_cnt;
`endif
        do_req(28'h100, 1, 3, 0, 1'b0, 1'b0, 1'b0);        // backpressure on 2nd command
`ifdef E1_WR_STALL_CNT_EN
        chk("stall_cnt", stall_cnt - sc0, 3);
`endif
        do_req(28'h100, 99, 0, 8, 1'b0, 1'b0, 1'b0);       // beats lag commands
        do_req(28'hFFFFFF0, 99, 0, 0, 1'b0, 1'b0, 1'b0);   // address wrap
        do_req(28'h300, 99, 0, 0, 1'b1, 1'b1, 1'b1);       // early last + busy request
        do_req(28'h340, 99, 0, 0, 1'b0, 1'b0, 1'b1);       // error stays sticky

        // Reset in the middle of ISSUE.
        addr_q.push_back(28'h400);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 28'h400;
        tick();
        bus.wr_req  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_wr_ready", 32'(bus.wr_ready), 1);
        chk("midrst_app_en", 32'(bus.app_en), 0);
        chk("midrst_app_addr", 32'(bus.app_addr), 0);
        chk("midrst_wr_done", 32'(bus.wr_done), 0);
        chk("midrst_proto_err", 32'(bus.proto_err), 0);
        addr_q.delete();
        done_q.delete();
        rst = 1'b0;
        tick();

        do_req(28'h800, 99, 0, 2, 1'b0, 1'b0, 1'b0);       // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
